// File: rtl/aexm_wbctl_pkg.sv
// Shared writeback-control types: register index and data widths, and the
// load-return queue entry record.
package aexm_wbctl_pkg;

  localparam int unsigned RegW = 5;
  localparam int unsigned DatW = 32;

  typedef logic [RegW-1:0] reg_idx_t;
  typedef logic [DatW-1:0] dat_t;

  // One late load return waiting for a free write-port slot.
  typedef struct packed {
    reg_idx_t rd;
    dat_t     dat;
  } ldq_ent_t;

endpackage

// File: rtl/aexm_wbctl_if.sv
// Writeback-control bus bundle.
//   pipeline side : gena, alu_vld/alu_rd/alu_dat, iss_vld/iss_rd, chk_ra/chk_rb/chk_rd
//   dcache side   : ld_vld/ld_rd/ld_dat in, ld_rdy out
//   results       : hz_stall, wr_en/wr_addr/wr_dat, waw_err
// slave is the writeback controller; master is whoever drives the requests.
interface aexm_wbctl_if
  import aexm_wbctl_pkg::*;
  ();

  logic     gena;
  logic     alu_vld;
  reg_idx_t alu_rd;
  dat_t     alu_dat;
  logic     ld_vld;
  reg_idx_t ld_rd;
  dat_t     ld_dat;
  logic     ld_rdy;
  logic     iss_vld;
  reg_idx_t iss_rd;
  reg_idx_t chk_ra;
  reg_idx_t chk_rb;
  reg_idx_t chk_rd;
  logic     hz_stall;
  logic     wr_en;
  reg_idx_t wr_addr;
  dat_t     wr_dat;
  logic     waw_err;

  modport slave (
    input  gena, alu_vld, alu_rd, alu_dat, ld_vld, ld_rd, ld_dat,
    input  iss_vld, iss_rd, chk_ra, chk_rb, chk_rd,
    output ld_rdy, hz_stall, wr_en, wr_addr, wr_dat, waw_err
  );

  modport master (
    output gena, alu_vld, alu_rd, alu_dat, ld_vld, ld_rd, ld_dat,
    output iss_vld, iss_rd, chk_ra, chk_rb, chk_rd,
    input  ld_rdy, hz_stall, wr_en, wr_addr, wr_dat, waw_err
  );

endinterface

// File: rtl/aexm_wbfifo.sv
// Load-return FIFO.
//   gclk, grst      : clock, synchronous active-high reset
//   push, push_ent  : enqueue request (ignored when full)
//   pop             : dequeue request (ignored when empty)
//   head            : entry at the read pointer
//   full            : registered, updated from the next-state count
//   empty           : derived from the current count; a push into an empty
//                     queue is therefore never visible for pop in the same cycle
module aexm_wbfifo
  import aexm_wbctl_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 2
) (
  input  logic     gclk,
  input  logic     grst,
  input  logic     push,
  input  ldq_ent_t push_ent,
  input  logic     pop,
  output ldq_ent_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(LDQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  ldq_ent_t            mem_q [LDQ_DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                full_q;
  logic                do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = full_q;
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge gclk) begin
    if (grst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_ent;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CntW'(LDQ_DEPTH));
    end
  end

endmodule

// File: rtl/aexm_wbctl.sv
// Register-file writeback controller.
//   gclk, grst : clock, synchronous active-high reset
//   bus        : aexm_wbctl_if.slave -- ALU writeback requests, late load
//                returns (queued), load-issue scoreboard, decode hazard check,
//                registered write port and write-after-write error pulse.
// The ALU always wins the write port; queued loads fill idle slots.
module aexm_wbctl
  import aexm_wbctl_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 2
) (
  input logic         gclk,
  input logic         grst,
  aexm_wbctl_if.slave bus
);

  logic        alu_acc;
  logic        ldq_push, ldq_pop, ldq_full, ldq_empty;
  ldq_ent_t    ldq_head;
  ldq_ent_t    ldq_in;

  logic        grant_vld;
  reg_idx_t    grant_rd;
  dat_t        grant_dat;

  logic [31:0] pend_q, pend_d;
  logic        wr_en_q, waw_q;
  reg_idx_t    wr_addr_q;
  dat_t        wr_dat_q;

  assign alu_acc  = bus.alu_vld & bus.gena;
  assign ldq_push = bus.ld_vld & ~ldq_full;
  assign ldq_pop  = ~alu_acc & ~ldq_empty;
  assign ldq_in   = '{rd: bus.ld_rd, dat: bus.ld_dat};

  aexm_wbfifo #(
    .LDQ_DEPTH (LDQ_DEPTH)
  ) u_ldq (
    .gclk     (gclk),
    .grst     (grst),
    .push     (ldq_push),
    .push_ent (ldq_in),
    .pop      (ldq_pop),
    .head     (ldq_head),
    .full     (ldq_full),
    .empty    (ldq_empty)
  );

  assign grant_vld = alu_acc | ldq_pop;
  assign grant_rd  = alu_acc ? bus.alu_rd  : ldq_head.rd;
  assign grant_dat = alu_acc ? bus.alu_dat : ldq_head.dat;

  // Clear before set so a same-cycle issue to the register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (ldq_pop) begin
      pend_d[ldq_head.rd] = 1'b0;
    end
    if (bus.iss_vld && bus.gena && (bus.iss_rd != '0)) begin
      pend_d[bus.iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      pend_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      waw_q     <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      // r0 grants still consume the slot but never write.
      wr_en_q <= grant_vld & (grant_rd != '0);
      if (grant_vld) begin
        wr_addr_q <= grant_rd;
        wr_dat_q  <= grant_dat;
      end
      waw_q <= alu_acc & (bus.alu_rd != '0) & pend_q[bus.alu_rd];
    end
  end

  assign bus.ld_rdy   = ~ldq_full;
  assign bus.hz_stall = pend_q[bus.chk_ra] | pend_q[bus.chk_rb] | pend_q[bus.chk_rd]
                      | (ldq_full & bus.ld_vld);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_dat   = wr_dat_q;
  assign bus.waw_err  = waw_q;

endmodule

// File: tb/tb_aexm_wbctl.sv
// Directed bench for aexm_wbctl (LDQ_DEPTH=2). Inputs change 1 time unit
// after each rising edge; outputs are checked 1 unit later.
module tb_aexm_wbctl;

  logic gclk;
  logic grst;
  int   n_chk;
  int   n_bad;

  aexm_wbctl_if bus ();

  aexm_wbctl #(
    .LDQ_DEPTH (2)
  ) dut (
    .gclk (gclk),
    .grst (grst),
    .bus  (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, ".en"}, 32'(bus.wr_en), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(bus.wr_addr), 32'(a));
      chk({tag, ".dat"}, bus.wr_dat, d);
    end
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    grst  = 1'b1;
    bus.gena = 1'b1;
    bus.alu_vld = 1'b0; bus.alu_rd = '0; bus.alu_dat = '0;
    bus.ld_vld  = 1'b0; bus.ld_rd  = '0; bus.ld_dat  = '0;
    bus.iss_vld = 1'b0; bus.iss_rd = '0;
    bus.chk_ra = '0; bus.chk_rb = '0; bus.chk_rd = '0;
    tick();
    tick();
    settle();
    chk("rst.wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst.waw", 32'(bus.waw_err), 32'd0);
    chk("rst.ld_rdy", 32'(bus.ld_rdy), 32'd1);
    chk("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst.wr_dat", bus.wr_dat, 32'd0);
    chk("rst.hz", 32'(bus.hz_stall), 32'd0);
    grst = 1'b0;

    // Issue to r5, then load return for r5.
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd5;
    tick();
    bus.iss_vld = 1'b0; bus.chk_ra = 5'd5;
    settle();
    chk("t1.hz_ra", 32'(bus.hz_stall), 32'd1);
    bus.chk_ra = 5'd0; bus.chk_rb = 5'd5;
    settle();
    chk("t1.hz_rb", 32'(bus.hz_stall), 32'd1);
    bus.chk_rb = 5'd0; bus.chk_ra = 5'd5;
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd5; bus.ld_dat = 32'hDEADBEEF;
    tick();
    bus.ld_vld = 1'b0;
    settle();
    chk("t1.hz_q", 32'(bus.hz_stall), 32'd1);
    chk("t1.wr_early", 32'(bus.wr_en), 32'd0);
    tick();
    settle();
    chk_wr("t1.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t1.hz_clr", 32'(bus.hz_stall), 32'd0);
    tick();
    chk("t1.wr_done", 32'(bus.wr_en), 32'd0);
    bus.chk_ra = 5'd0;

    // ALU busy for 4 cycles while one load is queued.
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd9; bus.ld_dat = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_vld = 1'b1; bus.alu_rd = 5'(i); bus.alu_dat = 32'h11 * i;
      tick();
      bus.ld_vld = 1'b0;
      settle();
      chk_wr("t2.alu", 1'b1, 5'(i), 32'h11 * i);
      chk("t2.waw", 32'(bus.waw_err), 32'd0);
    end
    bus.alu_vld = 1'b0;
    tick();
    settle();
    chk_wr("t2.ld", 1'b1, 5'd9, 32'h99);
    tick();
    chk("t2.idle", 32'(bus.wr_en), 32'd0);

    // Fill with ALU r0 hogging the port; third return dropped.
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd0; bus.alu_dat = 32'h0;
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd10; bus.ld_dat = 32'hA0;
    tick();
    settle();
    chk("t3.rdy1", 32'(bus.ld_rdy), 32'd1);
    bus.ld_rd = 5'd11; bus.ld_dat = 32'hB1;
    tick();
    bus.ld_rd = 5'd12; bus.ld_dat = 32'hC2;
    settle();
    chk("t3.rdy2", 32'(bus.ld_rdy), 32'd0);
    chk("t3.hz_full", 32'(bus.hz_stall), 32'd1);
    tick();
    bus.ld_vld = 1'b0;
    settle();
    chk("t3.rdy3", 32'(bus.ld_rdy), 32'd0);
    chk("t3.hz_nold", 32'(bus.hz_stall), 32'd0);
    chk("t3.r0_wr", 32'(bus.wr_en), 32'd0);
    bus.alu_vld = 1'b0;
    tick();
    settle();
    chk_wr("t3.d0", 1'b1, 5'd10, 32'hA0);
    chk("t3.rdy4", 32'(bus.ld_rdy), 32'd1);
    tick();
    settle();
    chk_wr("t3.d1", 1'b1, 5'd11, 32'hB1);
    tick();
    chk("t3.drop", 32'(bus.wr_en), 32'd0);

    // Five fill/drain rounds exercise pointer wrap.
    for (int i = 0; i < 5; i++) begin
      bus.alu_vld = 1'b1; bus.alu_rd = 5'd0;
      bus.ld_vld = 1'b1; bus.ld_rd = 5'(16 + i); bus.ld_dat = 32'hD0 + i;
      tick();
      bus.ld_rd = 5'(21 + i); bus.ld_dat = 32'hE0 + i;
      tick();
      bus.ld_vld = 1'b0; bus.alu_vld = 1'b0;
      settle();
      chk("t3w.full", 32'(bus.ld_rdy), 32'd0);
      tick();
      settle();
      chk_wr("t3w.a", 1'b1, 5'(16 + i), 32'hD0 + i);
      tick();
      settle();
      chk_wr("t3w.b", 1'b1, 5'(21 + i), 32'hE0 + i);
      chk("t3w.rdy", 32'(bus.ld_rdy), 32'd1);
    end
    tick();

    // Push and pop in the same cycle.
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd13; bus.ld_dat = 32'h13;
    tick();
    bus.ld_rd = 5'd14; bus.ld_dat = 32'h14;
    tick();
    bus.ld_vld = 1'b0;
    settle();
    chk_wr("t3p.a", 1'b1, 5'd13, 32'h13);
    chk("t3p.rdy", 32'(bus.ld_rdy), 32'd1);
    tick();
    settle();
    chk_wr("t3p.b", 1'b1, 5'd14, 32'h14);
    tick();

    // Issue to r7 in the same cycle a queued r7 return is granted.
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd7; bus.ld_dat = 32'h77;
    tick();
    bus.ld_vld = 1'b0; bus.iss_vld = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_vld = 1'b0; bus.chk_rd = 5'd7;
    settle();
    chk_wr("t4.wr", 1'b1, 5'd7, 32'h77);
    chk("t4.pend", 32'(bus.hz_stall), 32'd1);
    // ALU write to pending r7: WAW pulse, write still happens.
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd7; bus.alu_dat = 32'h7A;
    tick();
    bus.alu_vld = 1'b0;
    settle();
    chk("t4.waw", 32'(bus.waw_err), 32'd1);
    chk_wr("t4.alu", 1'b1, 5'd7, 32'h7A);
    tick();
    chk("t4.waw_off", 32'(bus.waw_err), 32'd0);
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd7; bus.ld_dat = 32'h78;
    tick();
    bus.ld_vld = 1'b0;
    tick();
    settle();
    chk("t4.clr", 32'(bus.hz_stall), 32'd0);
    bus.chk_rd = 5'd0;

    // r0 never written and never pending.
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd0; bus.alu_dat = 32'h12345678;
    tick();
    bus.alu_vld = 1'b0;
    settle();
    chk("t5.r0_wr", 32'(bus.wr_en), 32'd0);
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd0;
    tick();
    bus.iss_vld = 1'b0; bus.chk_ra = 5'd0;
    settle();
    chk("t5.r0_hz", 32'(bus.hz_stall), 32'd0);

    // Reset with two queued entries and r3 pending.
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd3;
    tick();
    bus.iss_vld = 1'b0;
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd0;
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd3; bus.ld_dat = 32'h33;
    tick();
    bus.ld_dat = 32'h34;
    tick();
    bus.ld_vld = 1'b0; bus.alu_vld = 1'b0; bus.chk_ra = 5'd3;
    settle();
    chk("t6.pre_hz", 32'(bus.hz_stall), 32'd1);
    grst = 1'b1;
    tick();
    settle();
    chk("t6.rdy", 32'(bus.ld_rdy), 32'd1);
    chk("t6.wr_en", 32'(bus.wr_en), 32'd0);
    chk("t6.hz", 32'(bus.hz_stall), 32'd0);
    chk("t6.addr", 32'(bus.wr_addr), 32'd0);
    chk("t6.dat", bus.wr_dat, 32'd0);
    grst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.nowr", 32'(bus.wr_en), 32'd0);
    end
    bus.chk_ra = 5'd0;
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd2; bus.alu_dat = 32'h2;
    tick();
    bus.alu_vld = 1'b0;
    settle();
    chk_wr("t6.alu", 1'b1, 5'd2, 32'h2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/aexm_wbctl.md
AEXM_WBCTL -- requirements
Module: aexm_wbctl

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 2, meaning the number of entries in the load-return queue (power of two, at least 2).
REQ-002 SHALL have port gclk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-003 SHALL have port grst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port gena, input, 1 bit: pipeline enable; it qualifies alu_vld and iss_vld only.
REQ-005 SHALL have ports alu_vld, alu_rd and alu_dat, inputs of 1, 5 and 32 bits: pipeline writeback request.
REQ-006 SHALL have ports ld_vld, ld_rd and ld_dat, inputs of 1, 5 and 32 bits: late load-data return from the dcache.
REQ-007 SHALL have port ld_rdy, output, 1 bit: the load queue can accept a return.
REQ-008 SHALL have ports iss_vld and iss_rd, inputs of 1 and 5 bits: a load issued to the dcache, naming its destination register.
REQ-009 SHALL have ports chk_ra, chk_rb and chk_rd, inputs of 5 bits each: source registers of the instruction in decode.
REQ-010 SHALL have port hz_stall, output, 1 bit: decode must stall.
REQ-011 SHALL have ports wr_en, wr_addr and wr_dat, outputs of 1, 5 and 32 bits: register-file write port.
REQ-012 SHALL have port waw_err, output, 1 bit: one-cycle pulse flagging a write-after-write violation.

Function
REQ-013 Write-port arbitration SHALL give an accepted ALU request (alu_vld & gena) absolute priority over the load-queue head.
REQ-014 The queue head SHALL be written only in a cycle with no accepted ALU request.
REQ-015 The write port SHALL be registered: a request granted in cycle N appears on wr_en, wr_addr and wr_dat in cycle N+1.
REQ-016 wr_en SHALL be held at 0 for any destination equal to 0, because r0 is never written; the grant is still consumed.
REQ-017 The load queue SHALL be a FIFO of LDQ_DEPTH entries, each holding {rd, data}.
REQ-018 A return SHALL be pushed when ld_vld & ld_rdy.
REQ-019 ld_rdy SHALL be the registered signal "not full".
REQ-020 Push and pop in the same cycle SHALL be legal at any occupancy, and the count SHALL be unchanged.
REQ-021 When the queue is empty, a push and a grant SHALL NOT bypass in the same cycle; the entry pops no earlier than the next cycle.
REQ-022 Read and write pointers SHALL wrap modulo LDQ_DEPTH.
REQ-023 ld_vld while ld_rdy=0 SHALL be ignored, and the return is dropped; the dcache is required to honour ld_rdy.
REQ-024 The scoreboard SHALL hold 32 pending bits, one per register.
REQ-025 A pending bit SHALL be set on iss_vld & gena when iss_rd is nonzero.
REQ-026 A pending bit SHALL be cleared when the load queue grants a write to that register.
REQ-027 If a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-028 Pending bit 0 SHALL always read 0.
REQ-029 hz_stall SHALL be combinational: pend[chk_ra] | pend[chk_rb] | pend[chk_rd] | (ldq_full & ld_vld).
REQ-030 waw_err SHALL pulse for one cycle, one cycle after an accepted ALU request whose rd is nonzero and pending.
REQ-031 The ALU write SHALL still be performed when waw_err fires.
REQ-032 No queue state or scoreboard state SHALL change in any cycle other than through the events defined above.

Reset
REQ-033 While grst is high, wr_en, waw_err, the queue count and all pending bits SHALL be 0.
REQ-034 While grst is high, ld_rdy SHALL be 1 and wr_addr and wr_dat SHALL be 0.
REQ-035 Reset mid-operation SHALL discard all queued returns and pending bits with no write issued.
REQ-036 Reset SHALL take priority over every other event in the same cycle.
REQ-037 In the first cycle after grst deasserts, the block SHALL accept requests.

Structure
REQ-038 The register index width (5), data width (32) and queue entry record SHALL live in the shared aexm package.
REQ-039 The load queue SHALL be a sub-module, aexm_wbfifo, with push/pop/full/empty ports and parameter LDQ_DEPTH.

Verification
REQ-040 Test: iss_vld with rd=5, then ld_vld with rd=5 and data=0xDEADBEEF, with no ALU traffic -> hz_stall=1 for chk_ra=5 until the write; wr_en=1, wr_addr=5, wr_dat=0xDEADBEEF two cycles after ld_vld; then pend[5]=0.
REQ-041 Test: alu_vld every cycle for 4 cycles while one load is queued -> the load writes on the first idle cycle; ALU writes appear in order at N+1.
REQ-042 Test: three back-to-back ld_vld with no grant opportunity and LDQ_DEPTH=2 -> ld_rdy=0 after two pushes; hz_stall=1 while ld_vld and full; pointers wrap correctly over 5 fill/drain cycles.
REQ-043 Test: iss_vld rd=7 and a queue grant to r7 in the same cycle -> pend[7] remains 1.
REQ-044 Test: alu_vld with rd=0 and data=0x12345678 -> wr_en=0; iss_vld with rd=0 -> hz_stall=0 for chk_ra=0.
REQ-045 Test: grst asserted with 2 entries queued and pend[3]=1 -> the next cycle shows ld_rdy=1, wr_en=0, hz_stall=0, and no write to r3 follows.
